// File: rtl/inst_queue.sv
// Dual-issue fetch-to-decode instruction queue: circular buffer, up to two entries in and out per cycle.
// Define INST_QUEUE_BYPASS_EN to forward inputs straight to the outputs when the queue is empty.
module inst_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [1:0]              in_valid,
    input  logic [PC_W-1:0]         in1_pc,
    input  logic [PC_W-1:0]         in1_npc,
    input  logic [INST_W-1:0]       in1_inst,
    input  logic [PC_W-1:0]         in2_pc,
    input  logic [PC_W-1:0]         in2_npc,
    input  logic [INST_W-1:0]       in2_inst,
    output logic                    in_ready,
    output logic [1:0]              out_valid,
    output logic [PC_W-1:0]         out1_pc,
    output logic [PC_W-1:0]         out1_npc,
    output logic [INST_W-1:0]       out1_inst,
    output logic [PC_W-1:0]         out2_pc,
    output logic [PC_W-1:0]         out2_npc,
    output logic [INST_W-1:0]       out2_inst,
    input  logic [1:0]              out_ack,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    entry_t     slot1, slot2, cmp0, cmp1, rd0, rd1, wr0;
    logic [1:0] n_in, n_out, n_pop, n_store, ack_eff, vld;
    logic       bypass, accept;

    assign slot1 = '{pc: in1_pc, npc: in1_npc, inst: in1_inst};
    assign slot2 = '{pc: in2_pc, npc: in2_npc, inst: in2_inst};

    // Valid input slots compacted so the older one is always first
    assign cmp0 = in_valid[0] ? slot1 : slot2;
    assign cmp1 = slot2;
    assign n_in = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};

    assign in_ready = (count <= CNT_W'(DEPTH - 2));

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && !flush && !rst;
    assign vld    = bypass ? {&in_valid, |in_valid}
                           : {count >= CNT_W'(2), count >= CNT_W'(1)};
    assign rd0    = bypass ? cmp0 : mem[rptr];
    assign rd1    = bypass ? cmp1 : mem[rptr + PTR_W'(1)];
`else
    assign bypass = 1'b0;
    assign vld    = {count >= CNT_W'(2), count >= CNT_W'(1)};
    assign rd0    = mem[rptr];
    assign rd1    = mem[rptr + PTR_W'(1)];
`endif

    // A lone ack on the second slot is meaningless and consumes nothing
    assign ack_eff = out_ack[0] ? (out_ack & vld) : 2'b00;
    assign n_out   = {1'b0, ack_eff[0]} + {1'b0, ack_eff[1]};
    assign accept  = in_ready && (|in_valid) && !flush;

    // Bypassed entries that decode consumed never touch storage
    assign n_pop   = (flush || bypass) ? 2'd0 : n_out;
    assign n_store = !accept ? 2'd0 : (bypass ? n_in - n_out : n_in);
    assign wr0     = (bypass && n_out != 2'd0) ? cmp1 : cmp0;

    assign out_valid = vld;
    assign out1_pc   = vld[0] ? rd0.pc   : '0;
    assign out1_npc  = vld[0] ? rd0.npc  : '0;
    assign out1_inst = vld[0] ? rd0.inst : '0;
    assign out2_pc   = vld[1] ? rd1.pc   : '0;
    assign out2_npc  = vld[1] ? rd1.npc  : '0;
    assign out2_inst = vld[1] ? rd1.inst : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PTR_W'(n_pop);
            wptr  <= wptr + PTR_W'(n_store);
            count <= count + CNT_W'(n_store) - CNT_W'(n_pop);
        end
    end

    // Storage is not reset; pointers and count alone define validity
    always_ff @(posedge clk) begin
        if (n_store != 2'd0) mem[wptr] <= wr0;
        if (n_store == 2'd2) mem[wptr + PTR_W'(1)] <= cmp1;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8: entry count; power of two, minimum 4.
REQ-002 Parameter PC_W, default 32: width of pc and npc fields.
REQ-003 Parameter INST_W, default 32: width of the instruction field.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  discard all entries (mispredict/branch redirect).
REQ-007 in_valid  input  2  per-slot write request from IF; bit0 = slot1 (older), bit1 = slot2.
REQ-008 in1_pc, in1_npc / in2_pc, in2_npc  input  PC_W each  pc and predicted next pc per slot.
REQ-009 in1_inst / in2_inst  input  INST_W each  instruction word per slot.
REQ-010 in_ready  output  1  queue accepts up to two entries this cycle.
REQ-011 out_valid  output  2  bit0 = head entry present, bit1 = head+1 entry present.
REQ-012 out1_pc, out1_npc, out1_inst / out2_pc, out2_npc, out2_inst  output  PC_W/PC_W/INST_W  head and head+1 entries.
REQ-013 out_ack  input  2  ID consumes the entry per bit; bit1 only with bit0.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage: circular buffer of DEPTH entries {pc, npc, inst}, read pointer, write pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-016 in_ready = (DEPTH - count >= 2); derived from registered count only, never from in_valid.
REQ-017 Enqueue when in_ready & |in_valid & !flush; n_in = popcount(in_valid).
REQ-018 in_valid 2'b11 writes slot1 at wptr, slot2 at wptr+1; 2'b01 writes slot1 at wptr; 2'b10 writes slot2 at wptr; wptr advances n_in.
REQ-019 Write data presented while in_ready low is dropped; IF holds it until in_ready is high.
REQ-020 out_valid[0] = (count >= 1), out_valid[1] = (count >= 2); out1 = entry[rptr], out2 = entry[rptr+1].
REQ-021 Out data fields are zero whenever the matching out_valid bit is low.
REQ-022 Dequeue n_out = popcount(out_ack & out_valid); acks on invalid slots ignored; out_ack 2'b10 treated as no dequeue.
REQ-023 Simultaneous enqueue and dequeue in one cycle: count_next = count + n_in - n_out; rptr advances n_out.
REQ-024 flush has priority: next edge sets rptr = wptr = 0, count = 0; same-cycle enqueue and dequeue discarded.
REQ-025 Latency without bypass: entry accepted at edge N appears on out at cycle N+1.
REQ-026 Order preserved strictly; no entry lost or duplicated across pointer wrap.
REQ-027 count never exceeds DEPTH; overflow is structurally prevented by REQ-016.

Reset
REQ-028 rst asserted: rptr = 0, wptr = 0, count = 0 immediately, independent of clk.
REQ-029 During reset: out_valid = 2'b00, all out data = 0, in_ready = 1, count = 0.
REQ-030 Storage contents need not be cleared; reset mid-operation discards all entries and any in-flight write.

Configuration
REQ-031 Macro INST_QUEUE_BYPASS_EN defined: when count = 0 and !flush, valid input slots appear combinationally on out1/out2 (compacted, older first) in the same cycle; acknowledged bypass entries are not stored, unacknowledged ones are enqueued normally.
REQ-032 INST_QUEUE_BYPASS_EN undefined: no combinational in-to-out path; REQ-025 latency applies always.

Verification
REQ-033 Reset, then in_valid=2'b11 with pc 0x100/0x104, out_ack=0 -> next cycle out_valid=2'b11, out1_pc=0x100, out2_pc=0x104, count=2.
REQ-034 DEPTH=8: enqueue 2'b11 four times, no ack -> count=8, in_ready=0; fifth pair dropped; ack 2'b11 -> count=6, in_ready=1.
REQ-035 count=7, in_valid=2'b01 blocked (in_ready=0); ack 2'b01 same cycle -> count=6, in_ready high next cycle.
REQ-036 Continuous in_valid=2'b11, out_ack=2'b11 for 20 cycles -> pcs emerge in order across wrap, count steady at 2.
REQ-037 count=5, flush with in_valid=2'b11 and out_ack=2'b11 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-038 INST_QUEUE_BYPASS_EN, empty, in_valid=2'b10 pc 0x200, out_ack=2'b01 -> same cycle out1_pc=0x200, out_valid[0]=1; next cycle count=0.
